// File: rtl/vga_timing_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_pipe
//  Brief    : VGA raster counters, framebuffer read addressing and
//             sync/visible-flag alignment to the framebuffer read latency.
//  Revision : 1.0 - initial release
// ============================================================================
module vga_timing_pipe #(
    parameter int WIDTH  = 12,
    parameter int HSIZE  = 800,
    parameter int HFP    = 856,
    parameter int HSP    = 976,
    parameter int HMAX   = 1040,
    parameter int VSIZE  = 600,
    parameter int VFP    = 637,
    parameter int VSP    = 643,
    parameter int VMAX   = 666,
    parameter int HSPP   = 1,
    parameter int VSPP   = 1,
    parameter int LAT    = 2,
    parameter int ADDR_W = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] fb_base,
    input  logic [31:0]       data,
    output logic [WIDTH-1:0]  hdata,
    output logic [WIDTH-1:0]  vdata,
    output logic [ADDR_W-1:0] address,
    output logic              rd_en,
    output logic              hsync,
    output logic              vsync,
    output logic              data_enable,
    output logic [7:0]        red,
    output logic [7:0]        green,
    output logic [7:0]        blue,
    output logic              frame_start,
    output logic              line_start
);

    localparam logic [WIDTH-1:0] c_hsize     = WIDTH'(HSIZE);
    localparam logic [WIDTH-1:0] c_hfp       = WIDTH'(HFP);
    localparam logic [WIDTH-1:0] c_hsp       = WIDTH'(HSP);
    localparam logic [WIDTH-1:0] c_hmax_last = WIDTH'(HMAX - 1);
    localparam logic [WIDTH-1:0] c_vsize     = WIDTH'(VSIZE);
    localparam logic [WIDTH-1:0] c_vfp       = WIDTH'(VFP);
    localparam logic [WIDTH-1:0] c_vsp       = WIDTH'(VSP);
    localparam logic [WIDTH-1:0] c_vmax_last = WIDTH'(VMAX - 1);
    localparam logic             c_hs_on     = (HSPP != 0);
    localparam logic             c_vs_on     = (VSPP != 0);

    logic [WIDTH-1:0]  r_hcnt;
    logic [WIDTH-1:0]  r_vcnt;
    logic [ADDR_W-1:0] r_addr;
    logic [LAT-1:0]    r_hs_pipe;
    logic [LAT-1:0]    r_vs_pipe;
    logic [LAT-1:0]    r_de_pipe;

    logic w_de;
    logic w_hs;
    logic w_vs;
    logic w_line_end;
    logic w_frame_end;
    logic w_unused;

    always_comb begin
        w_de        = (r_hcnt < c_hsize) && (r_vcnt < c_vsize);
        w_hs        = ((r_hcnt >= c_hfp) && (r_hcnt < c_hsp)) ? c_hs_on : ~c_hs_on;
        w_vs        = ((r_vcnt >= c_vfp) && (r_vcnt < c_vsp)) ? c_vs_on : ~c_vs_on;
        w_line_end  = (r_hcnt == c_hmax_last);
        w_frame_end = w_line_end && (r_vcnt == c_vmax_last);
    end

    // The address points at the pixel being fetched this cycle; the new base
    // is only picked up on the very last cycle of a frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
            r_addr <= fb_base;
        end else begin
            if (w_line_end) begin
                r_hcnt <= '0;
                r_vcnt <= (r_vcnt == c_vmax_last) ? '0 : r_vcnt + 1'b1;
            end else begin
                r_hcnt <= r_hcnt + 1'b1;
            end

            if (w_frame_end) begin
                r_addr <= fb_base;
            end else if (w_de) begin
                r_addr <= r_addr + 1'b1;
            end
        end
    end

    // Delay lines matching the framebuffer read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hs_pipe <= {LAT{~c_hs_on}};
            r_vs_pipe <= {LAT{~c_vs_on}};
            r_de_pipe <= '0;
        end else begin
            for (int i = LAT - 1; i > 0; i--) begin
                r_hs_pipe[i] <= r_hs_pipe[i-1];
                r_vs_pipe[i] <= r_vs_pipe[i-1];
                r_de_pipe[i] <= r_de_pipe[i-1];
            end
            r_hs_pipe[0] <= w_hs;
            r_vs_pipe[0] <= w_vs;
            r_de_pipe[0] <= w_de;
        end
    end

    assign hdata       = r_hcnt;
    assign vdata       = r_vcnt;
    assign address     = r_addr;
    assign rd_en       = w_de;
    assign frame_start = (r_hcnt == '0) && (r_vcnt == '0);
    assign line_start  = (r_hcnt == '0);
    assign hsync       = r_hs_pipe[LAT-1];
    assign vsync       = r_vs_pipe[LAT-1];
    assign data_enable = r_de_pipe[LAT-1];
    assign red         = data_enable ? data[23:16] : 8'd0;
    assign green       = data_enable ? data[15:8]  : 8'd0;
    assign blue        = data_enable ? data[7:0]   : 8'd0;

    // The top byte of the read word carries no colour information.
    assign w_unused = &{1'b0, data[31:24]};

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_timing_pipe
//  Brief    : Randomized scoreboard bench for vga_timing_pipe, LAT = 1, 2, 4.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_pipe;

    localparam int AW    = 19;
    localparam int W     = 12;
    localparam int NDUT  = 3;
    localparam int NCYC  = 1400;
    localparam int FRAME = 48;

    typedef struct {
        int         cyc;
        int         h;
        int         v;
        int         addr;
        int         rd;
        int         fs;
        int         ls;
        logic [2:0] hs;
        logic [2:0] vs;
    } exp_t;

    typedef struct {
        int          due;
        int          ep;
        logic [23:0] rgb;
    } rgb_t;

    logic          clk;
    logic          rst;
    logic [AW-1:0] fb_base;
    logic [31:0]   dat   [NDUT];
    logic [W-1:0]  hd    [NDUT];
    logic [W-1:0]  vd    [NDUT];
    logic [AW-1:0] addr  [NDUT];
    logic          rd    [NDUT];
    logic          hs    [NDUT];
    logic          vs    [NDUT];
    logic          de    [NDUT];
    logic [7:0]    r_o   [NDUT];
    logic [7:0]    g_o   [NDUT];
    logic [7:0]    b_o   [NDUT];
    logic          fs    [NDUT];
    logic          ls    [NDUT];

    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
        vga_timing_pipe #(
            .WIDTH(W), .HSIZE(4), .HFP(5), .HSP(6), .HMAX(8),
            .VSIZE(3), .VFP(4), .VSP(5), .VMAX(6), .HSPP(1), .VSPP(1),
            .LAT((gi == 0) ? 1 : ((gi == 1) ? 2 : 4)), .ADDR_W(AW)
        ) u_dut (
            .clk(clk), .rst(rst), .fb_base(fb_base), .data(dat[gi]),
            .hdata(hd[gi]), .vdata(vd[gi]), .address(addr[gi]), .rd_en(rd[gi]),
            .hsync(hs[gi]), .vsync(vs[gi]), .data_enable(de[gi]),
            .red(r_o[gi]), .green(g_o[gi]), .blue(b_o[gi]),
            .frame_start(fs[gi]), .line_start(ls[gi])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t        exp_q [$];
    rgb_t        rgb_q [NDUT][$];
    logic [31:0] memq  [NDUT][$];
    int          raw_hs [NCYC];
    int          raw_vs [NCYC];
    int          ep_hist [NCYC];
    int          epoch;
    int          n_pass;
    int          n_total;

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 2 : 4);
    endfunction

    function automatic logic [23:0] pix(input logic [AW-1:0] a);
        return {a[7:0], a[15:8], a[7:0] ^ 8'hC3 ^ {5'b0, a[18:16]}};
    endfunction

    task automatic chk(input string nm, input int d, input int cyc,
                       input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s lat%0d cycle %0d: got %0d expected %0d",
                      nm, lat_of(d), cyc, act, exp);
    endtask

    // Stimulus and reference model: frame position, base and the expected
    // responses are derived from the raster rules with plain arithmetic.
    initial begin
        int  pos, base, fr, h, v, cnt, a, L;
        bit  did13, vis;
        exp_t e;
        rst     = 1'b1;
        fb_base = AW'(100);
        for (int d = 0; d < NDUT; d++) dat[d] = '0;
        pos = 0; base = 0; fr = 0; did13 = 0; epoch = 0;
        for (int j = 0; j < NCYC; j++) begin
            @(negedge clk);
            if (rst) begin
                pos = 0; base = int'(fb_base); epoch++;
            end else if (pos == FRAME - 1) begin
                pos = 0; base = int'(fb_base); fr++;
            end else begin
                pos++;
            end
            h   = pos % 8;
            v   = pos / 8;
            vis = (h < 4) && (v < 3);
            cnt = (v < 3) ? v * 4 + ((h < 4) ? h : 4) : 12;
            a   = (base + cnt) & ((1 << AW) - 1);
            raw_hs[j]  = (h == 5) ? 1 : 0;
            raw_vs[j]  = (v == 4) ? 1 : 0;
            ep_hist[j] = epoch;

            e.cyc = j; e.h = h; e.v = v; e.addr = a; e.rd = vis ? 1 : 0;
            e.fs = (pos == 0) ? 1 : 0; e.ls = (h == 0) ? 1 : 0;
            for (int d = 0; d < NDUT; d++) begin
                L = lat_of(d);
                e.hs[d] = (j >= L && ep_hist[j-L] == epoch) ? raw_hs[j-L][0] : 1'b0;
                e.vs[d] = (j >= L && ep_hist[j-L] == epoch) ? raw_vs[j-L][0] : 1'b0;
            end
            exp_q.push_back(e);

            // Framebuffer: answers the DUT's own request LAT cycles later.
            for (int d = 0; d < NDUT; d++) begin
                L = lat_of(d);
                memq[d].push_back(rd[d] ? {8'($urandom), pix(addr[d])} : $urandom);
                dat[d] = (memq[d].size() > L) ? memq[d][memq[d].size()-1-L] : $urandom;
                while (memq[d].size() > 6) void'(memq[d].pop_front());
                if (vis) rgb_q[d].push_back('{j + L, epoch, pix(AW'(a))});
            end

            rst = 1'b0;
            if (j < 2) rst = 1'b1;
            if (fr == 3 && pos == 13 && !did13) begin rst = 1'b1; did13 = 1; end
            if (j > 1100 && $urandom_range(0, 59) == 0) rst = 1'b1;
            if (fr == 1 && pos == 20) fb_base = AW'(200);
            if (fr == 5 && pos == 30) fb_base = AW'((1 << AW) - 6);
            if (fr >= 7 && $urandom_range(0, 9) == 0) fb_base = AW'($urandom);
        end
        @(negedge clk);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Monitor: pops the expected response for each presented cycle.
    initial begin
        exp_t e;
        rgb_t r;
        n_pass = 0; n_total = 0;
        for (int jm = 0; jm < NCYC; jm++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0) begin
                chk("exp_queue_empty", 0, jm, 0, 1);
                continue;
            end
            e = exp_q.pop_front();
            for (int d = 0; d < NDUT; d++) begin
                chk("hdata",       d, jm, hd[d],   e.h);
                chk("vdata",       d, jm, vd[d],   e.v);
                chk("address",     d, jm, addr[d], e.addr);
                chk("rd_en",       d, jm, rd[d],   e.rd);
                chk("frame_start", d, jm, fs[d],   e.fs);
                chk("line_start",  d, jm, ls[d],   e.ls);
                chk("hsync",       d, jm, hs[d],   e.hs[d]);
                chk("vsync",       d, jm, vs[d],   e.vs[d]);
                while (rgb_q[d].size() > 0 && rgb_q[d][0].ep != epoch)
                    void'(rgb_q[d].pop_front());
                if (rgb_q[d].size() > 0 && rgb_q[d][0].due == jm) begin
                    r = rgb_q[d].pop_front();
                    chk("data_enable", d, jm, de[d], 1);
                    chk("rgb",         d, jm, {r_o[d], g_o[d], b_o[d]}, r.rgb);
                end else begin
                    chk("data_enable", d, jm, de[d], 0);
                    chk("rgb_idle",    d, jm, {r_o[d], g_o[d], b_o[d]}, 0);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/vga_timing_pipe.md
VGA_TIMING_PIPE -- requirements
Module: vga_timing_pipe

Interface
REQ-001 The module SHALL have exactly one clock and one reset: reset is synchronous and active-high; ports are named clk and rst.
REQ-002 The module SHALL have these parameters (name, default, meaning):
- WIDTH, 12, bits of hdata/vdata
- HSIZE, 800, visible pixels per line
- HFP, 856, first hcnt of hsync pulse
- HSP, 976, first hcnt after hsync pulse
- HMAX, 1040, total pixels per line
- VSIZE, 600, visible lines
- VFP, 637, first vcnt of vsync pulse
- VSP, 643, first vcnt after vsync pulse
- VMAX, 666, total lines
- HSPP, 1, hsync active level
- VSPP, 1, vsync active level
- LAT, 2, framebuffer read latency in cycles, legal 1..4
- ADDR_W, 19, framebuffer address width
REQ-003 The module SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, pixel clock
- rst, in, 1, synchronous active-high reset
- fb_base, in, ADDR_W, framebuffer base address for the next frame
- data, in, 32, read data {8'x, R, G, B}, valid LAT cycles after rd_en
- hdata, out, WIDTH, raw horizontal counter
- vdata, out, WIDTH, raw vertical counter
- address, out, ADDR_W, read address
- rd_en, out, 1, read strobe
- hsync, out, 1, aligned hsync
- vsync, out, 1, aligned vsync
- data_enable, out, 1, aligned visible flag
- red/green/blue, out, 8 each, aligned pixel colour
- frame_start, out, 1, raw-stage frame pulse
- line_start, out, 1, raw-stage line pulse

Function
REQ-004 hdata SHALL increment each cycle and wrap from HMAX-1 to 0; on that wrap vdata SHALL increment, wrapping from VMAX-1 to 0.
REQ-005 Raw visible flag de_raw = (hdata<HSIZE)&(vdata<VSIZE); rd_en SHALL equal de_raw in the same cycle.
REQ-006 address SHALL always hold the address of the current raw pixel while de_raw=1, and SHALL advance by 1 (mod 2^ADDR_W) only in cycles where de_raw=1; it SHALL hold otherwise.
REQ-007 When hdata=HMAX-1 and vdata=VMAX-1, the next-cycle address SHALL be fb_base sampled in that cycle; fb_base changes at any other time SHALL have no effect until then.
REQ-008 frame_start SHALL be 1 exactly when hdata=0 and vdata=0; line_start SHALL be 1 exactly when hdata=0.
REQ-009 Raw hs = (hdata>=HFP && hdata<HSP) ? HSPP : !HSPP; raw vs is the same form with vdata, VFP, VSP, VSPP.
REQ-010 hsync, vsync and data_enable SHALL be raw hs, vs and de_raw delayed by exactly LAT registered stages.
REQ-011 red/green/blue SHALL equal data[23:16]/[15:8]/[7:0] when data_enable=1, and SHALL be 0 otherwise (combinational gating of the input).
REQ-012 Address arithmetic SHALL wrap modulo 2^ADDR_W without error flags.

Reset
REQ-013 While rst=1: hdata=0, vdata=0, address=fb_base, all delay stages cleared to hs=!HSPP, vs=!VSPP, de=0.
REQ-014 In the first cycle after rst deasserts, the block SHALL be in frame position (0,0) with frame_start=1 and rd_en=1.
REQ-015 Reset asserted mid-frame SHALL abort the frame; no stale data_enable pulse SHALL appear after reset.

Verification
Bench parameters: HSIZE=4, HFP=5, HSP=6, HMAX=8, VSIZE=3, VFP=4, VSP=5, VMAX=6, LAT=2, HSPP=VSPP=1, fb_base=100.
REQ-016 Release reset -> address 100,101,102,103 with rd_en=1 at hdata 0..3 of line 0; 104..107 on line 1; address holds 112 from line 3 onward; returns to 100 at the next frame (cycle 48).
REQ-017 data=hdata-tagged pattern with 2-cycle memory model -> data_enable high in cycles 2..5 of each visible line and RGB match the pixel issued 2 cycles earlier; RGB=0 elsewhere.
REQ-018 Check sync alignment -> hsync=1 only in cycles where the raw hdata was 5 two cycles earlier; vsync=1 for the 8 cycles aligned to raw vdata=4.
REQ-019 Set fb_base=200 at frame cycle 20 -> the current frame is unaffected; the next frame starts at address 200.
REQ-020 Pulse rst for 1 cycle at frame cycle 13 -> next cycle hdata=0, vdata=0, address=fb_base, frame_start=1, data_enable=0 for 2 cycles.
REQ-021 Rerun REQ-017 with LAT=1 and LAT=4 -> the alignment offset equals LAT.
